// File: rtl/bus_grant_sequencer_pkg.sv
// rtl/bus_grant_sequencer_pkg.sv - shared types, sizes and select decode for the bus grant sequencer
package bus_grant_sequencer_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Same pattern the downstream 2:4 decoder produces for an enabled select.
    function automatic logic [0:NUM_REQ-1] decode_sel(input logic [SEL_W-1:0] s);
        logic [0:NUM_REQ-1] pat;
        case (s)
            2'd0:    pat = 4'b0111;
            2'd1:    pat = 4'b1011;
            2'd2:    pat = 4'b1101;
            default: pat = 4'b1110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bus_grant_sequencer_if.sv
// rtl/bus_grant_sequencer_if.sv - request/grant bundle between requesters, sequencer and decoder
interface bus_grant_sequencer_if;
    import bus_grant_sequencer_pkg::*;

    logic [0:NUM_REQ-1] req_n;
    logic [SEL_W-1:0]   sel;
    logic               enable_n;
    logic [0:NUM_REQ-1] grant_n;
    logic               timeout;

    modport master (input req_n, output sel, output enable_n, output grant_n, output timeout);
    modport slave  (output req_n, input sel, input enable_n, input grant_n, input timeout);

endinterface

// File: rtl/bus_grant_sequencer_rr_pick4.sv
// rtl/bus_grant_sequencer_rr_pick4.sv - round-robin pick of the first eligible index after last
module rr_pick4 (
    input  logic [0:3] eligible,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        winner = last;
        any    = 1'b0;
        idx    = 2'd0;
        // Offset 4 wraps back to last itself, so the previous owner is scanned last.
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!any && eligible[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_grant_sequencer.sv
// rtl/bus_grant_sequencer.sv - round-robin bus owner sequencer with hold limit and turnaround gap
module bus_grant_sequencer #(
    parameter int HOLD_MAX   = 15,
    parameter int TURNAROUND = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bus_grant_sequencer_if.master bus
);
    import bus_grant_sequencer_pkg::*;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [7:0] TURN_LAST = 8'(TURNAROUND - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d, last_q, last_d, winner;
    logic               en_q, en_d, to_q, to_d, any;
    logic [7:0]         cnt_q, cnt_d;
    logic [0:NUM_REQ-1] lock_q, lock_d, grant_q, grant_d, eligible;

    assign eligible = ~bus.req_n & ~lock_q;

    rr_pick4 u_pick (
        .eligible (eligible),
        .last     (last_q),
        .winner   (winner),
        .any      (any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= 2'd3;
            en_q    <= 1'b1;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            lock_q  <= '0;
            grant_q <= '1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            en_q    <= en_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        en_d    = en_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        lock_d  = lock_q & ~bus.req_n;

        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_OWN;
                    sel_d   = winner;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                // A voluntary release takes priority over a coincident hold-limit expiry.
                if (bus.req_n[sel_q]) begin
                    state_d = ST_GAP;
                    en_d    = 1'b1;
                    last_d  = sel_q;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d        = ST_GAP;
                    en_d           = 1'b1;
                    last_d         = sel_q;
                    cnt_d          = '0;
                    to_d           = 1'b1;
                    lock_d[sel_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        grant_d = en_d ? '1 : decode_sel(sel_d);
    end

    assign bus.sel      = sel_q;
    assign bus.enable_n = en_q;
    assign bus.grant_n  = grant_q;
    assign bus.timeout  = to_q;

endmodule
